// File: rtl/insfetch_pkg.sv
// insfetch_pkg: opcodes, BHT reset value and fetch FSM states shared by the fetch stage
package insfetch_pkg;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [1:0] BHT_INIT = 2'b01;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/insfetch_bht.sv
// insfetch_bht: table of 2-bit saturating branch counters, async read, trained by ROB commits
module insfetch_bht
  import insfetch_pkg::*;
#(
  parameter int BHT_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic [1:0]          ctr,
  input  logic                upd,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                taken
);
  localparam int SIZE = 1 << BHT_BITS;
  logic [1:0] ctrs [SIZE];
  logic [1:0] cur;
  assign ctr = ctrs[rd_idx];
  assign cur = ctrs[upd_idx];
  // saturating train; a same-cycle read still returns the pre-update value
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SIZE; i++) ctrs[i] <= BHT_INIT;
    end else if (rdy_in && upd) begin
      ctrs[upd_idx] <= taken ? ((cur == 2'd3) ? cur : cur + 2'd1)
                             : ((cur == 2'd0) ? cur : cur - 2'd1);
    end
  end
endmodule

// File: rtl/insfetch.sv
// insfetch: fetch stage holding the PC, one outstanding icache request and next-PC prediction
module insfetch
  import insfetch_pkg::*;
#(
  parameter int          BHT_BITS = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_data,
  input  logic        f_stall,
  output logic        is_ins,
  output logic [31:0] ins_addr,
  output logic [31:0] ins,
  output logic        pred_jmp,
  output logic [31:0] pred_another,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        rob_br_upd,
  input  logic [31:0] rob_br_pc,
  input  logic        rob_br_taken
);
  fetch_state_t state, state_nxt;
  logic [31:0] pc, imm_b, imm_j, seq_pc, br_pc, jal_pc, nxt_pc, another;
  logic [1:0]  ctr;
  logic        is_b, is_j, br_taken, p_jmp, fire, take, done;
  logic        unused_ok;
  assign unused_ok = ^{rob_br_pc[31:BHT_BITS+2], rob_br_pc[1:0]};
  insfetch_bht #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .rd_idx  (ic_addr[BHT_BITS+1:2]),
    .ctr     (ctr),
    .upd     (rob_br_upd),
    .upd_idx (rob_br_pc[BHT_BITS+1:2]),
    .taken   (rob_br_taken)
  );
  // decode the returning word and predict the PC that follows it
  always_comb begin
    imm_b    = {{20{ic_data[31]}}, ic_data[7], ic_data[30:25], ic_data[11:8], 1'b0};
    imm_j    = {{12{ic_data[31]}}, ic_data[19:12], ic_data[20], ic_data[30:21], 1'b0};
    seq_pc   = ic_addr + 32'd4;
    br_pc    = ic_addr + imm_b;
    jal_pc   = ic_addr + imm_j;
    is_b     = ic_data[6:0] == OP_B;
    is_j     = ic_data[6:0] == OP_JAL;
    br_taken = is_b && ctr[1];
    p_jmp    = is_j || br_taken;
    nxt_pc   = is_j ? jal_pc : br_taken ? br_pc : seq_pc;
    another  = (is_b && !br_taken) ? br_pc : seq_pc;
  end
  // next state: a flush always beats starting a new fetch; abandoned words are drained in DROP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (!rob_clear && !f_stall) ? WAIT : IDLE;
      WAIT:    state_nxt = ic_valid ? IDLE : rob_clear ? DROP : WAIT;
      DROP:    state_nxt = ic_valid ? IDLE : DROP;
      default: state_nxt = IDLE;
    endcase
    fire = state == IDLE && state_nxt == WAIT;
    take = state == WAIT && ic_valid && !rob_clear;
    done = state != IDLE && ic_valid;
  end
  // state register, frozen while rdy_in is low
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end
  // PC, icache request and decode-facing output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc           <= RESET_PC;
      ic_req       <= 1'b0;
      ic_addr      <= RESET_PC;
      is_ins       <= 1'b0;
      ins_addr     <= 32'h0;
      ins          <= 32'h0;
      pred_jmp     <= 1'b0;
      pred_another <= 32'h0;
    end else if (rdy_in) begin
      is_ins <= take;
      if (fire) begin
        ic_req  <= 1'b1;
        ic_addr <= pc;
      end else if (done) begin
        ic_req <= 1'b0;
      end
      if (rob_clear) pc <= rob_new_pc;
      else if (take) pc <= nxt_pc;
      if (take) begin
        ins          <= ic_data;
        ins_addr     <= ic_addr;
        pred_jmp     <= p_jmp;
        pred_another <= another;
      end
    end else begin
      is_ins <= 1'b0;
    end
  end
endmodule

// File: tb/tb_insfetch.sv
// tb_insfetch: table-driven and scripted checks of the fetch stage with a scoreboard on is_ins
module tb_insfetch;
  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] BEQM8 = 32'hFE000CE3;
  localparam logic [31:0] BEQP16 = 32'h00000863;
  localparam logic [31:0] JAL100 = 32'h1000006F;
  localparam logic [31:0] JALM4 = 32'hFFDFF06F;
  localparam logic [31:0] JALR  = 32'h00008067;
  logic clk_in = 1'b0, rst_in, rdy_in, ic_req, ic_valid, f_stall, is_ins, pred_jmp;
  logic rob_clear, rob_br_upd, rob_br_taken;
  logic [31:0] ic_addr, ic_data, ins_addr, ins, pred_another, rob_new_pc, rob_br_pc;
  typedef struct {logic [31:0] a; logic [31:0] i; logic pj; logic [31:0] pa;} exp_t;
  typedef struct {logic [31:0] pc; logic [31:0] word; logic pj; logic [31:0] pa; logic [31:0] nxt;} vec_t;
  exp_t sb[$];
  vec_t vt[8];
  int n_pass = 0, n_tot = 0, n_ins = 0, k;
  insfetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_valid(ic_valid), .ic_data(ic_data), .f_stall(f_stall), .is_ins(is_ins),
    .ins_addr(ins_addr), .ins(ins), .pred_jmp(pred_jmp), .pred_another(pred_another),
    .rob_clear(rob_clear), .rob_new_pc(rob_new_pc), .rob_br_upd(rob_br_upd),
    .rob_br_pc(rob_br_pc), .rob_br_taken(rob_br_taken)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic redirect(input logic [31:0] p);
    rob_clear = 1'b1;
    rob_new_pc = p;
    cyc(1);
    rob_clear = 1'b0;
  endtask
  task automatic train(input logic [31:0] p, input logic t, input int n);
    repeat (n) begin
      rob_br_upd = 1'b1;
      rob_br_pc = p;
      rob_br_taken = t;
      cyc(1);
    end
    rob_br_upd = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input logic pj,
                       input logic [31:0] pa, input int lat);
    f_stall = 1'b0;
    cyc(1);
    f_stall = 1'b1;
    chk("ic_req_rise", ic_req, 1);
    chk("ic_addr", ic_addr, a);
    cyc(lat - 1);
    ic_valid = 1'b1;
    ic_data = w;
    sb.push_back('{a, w, pj, pa});
    cyc(1);
    ic_valid = 1'b0;
    chk("ic_req_fall", ic_req, 0);
  endtask
  task automatic fill(input logic [31:0] a);
    fetch(a, ADDI, 1'b0, a + 32'd4, 1);
  endtask
  always @(negedge clk_in) begin
    if (is_ins === 1'b1) begin
      exp_t e;
      n_ins++;
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL spurious_is_ins: got is_ins=1 at ins_addr %h want no instruction", ins_addr);
      end else begin
        e = sb.pop_front();
        chk("ins_addr", ins_addr, e.a);
        chk("ins", ins, e.i);
        chk("pred_jmp", pred_jmp, e.pj);
        chk("pred_another", pred_another, e.pa);
      end
    end
  end
  initial begin
    vt[0] = '{32'h00000040, ADDI,   1'b0, 32'h00000044, 32'h00000044};
    vt[1] = '{32'h00000010, BEQM8,  1'b0, 32'h00000008, 32'h00000014};
    vt[2] = '{32'h00000020, JAL100, 1'b1, 32'h00000024, 32'h00000120};
    vt[3] = '{32'h00000030, JALR,   1'b0, 32'h00000034, 32'h00000034};
    vt[4] = '{32'h00000050, BEQP16, 1'b0, 32'h00000060, 32'h00000054};
    vt[5] = '{32'h00000064, JALM4,  1'b1, 32'h00000068, 32'h00000060};
    vt[6] = '{32'hFFFFFFF0, JAL100, 1'b1, 32'hFFFFFFF4, 32'h000000F0};
    vt[7] = '{32'hFFFFFFFC, ADDI,   1'b0, 32'h00000000, 32'h00000000};
    rst_in = 1'b1; rdy_in = 1'b1; f_stall = 1'b1; ic_valid = 1'b0; ic_data = 32'h0;
    rob_clear = 1'b0; rob_new_pc = 32'h0; rob_br_upd = 1'b0; rob_br_pc = 32'h0; rob_br_taken = 1'b0;
    cyc(2);
    rst_in = 1'b0;
    cyc(1);
    chk("rst_ic_req", ic_req, 0);
    chk("rst_is_ins", is_ins, 0);
    chk("rst_pred_jmp", pred_jmp, 0);
    chk("rst_ins", ins, 0);
    chk("rst_ins_addr", ins_addr, 0);
    chk("rst_pred_another", pred_another, 0);
    fetch(32'h0, ADDI, 1'b0, 32'h4, 2);
    fetch(32'h4, ADDI, 1'b0, 32'h8, 2);
    fill(32'h8);
    for (int i = 0; i < 8; i++) begin
      redirect(vt[i].pc);
      fetch(vt[i].pc, vt[i].word, vt[i].pj, vt[i].pa, 1 + i % 3);
      fill(vt[i].nxt);
    end
    train(32'h10, 1'b1, 2);
    redirect(32'h10);
    fetch(32'h10, BEQM8, 1'b1, 32'h14, 1);
    fill(32'h8);
    train(32'h10, 1'b1, 2);
    train(32'h10, 1'b0, 2);
    redirect(32'h10);
    fetch(32'h10, BEQM8, 1'b0, 32'h8, 1);
    fill(32'h14);
    train(32'h10, 1'b0, 2);
    train(32'h10, 1'b1, 2);
    redirect(32'h10);
    fetch(32'h10, BEQM8, 1'b1, 32'h14, 2);
    fill(32'h8);
    rdy_in = 1'b0;
    f_stall = 1'b0;
    train(32'h10, 1'b0, 2);
    chk("rdy_low_no_req", ic_req, 0);
    f_stall = 1'b1;
    rdy_in = 1'b1;
    redirect(32'h10);
    fetch(32'h10, BEQM8, 1'b1, 32'h14, 1);
    fill(32'h8);
    f_stall = 1'b0;
    cyc(1);
    f_stall = 1'b1;
    rob_clear = 1'b1;
    rob_new_pc = 32'h200;
    cyc(1);
    rob_clear = 1'b0;
    chk("drop_holds_req", ic_req, 1);
    cyc(2);
    ic_valid = 1'b1;
    ic_data = JAL100;
    cyc(1);
    ic_valid = 1'b0;
    chk("drop_req_fall", ic_req, 0);
    fetch(32'h200, ADDI, 1'b0, 32'h204, 1);
    f_stall = 1'b0;
    cyc(1);
    f_stall = 1'b1;
    cyc(1);
    rob_clear = 1'b1;
    rob_new_pc = 32'h300;
    ic_valid = 1'b1;
    ic_data = JAL100;
    cyc(1);
    rob_clear = 1'b0;
    ic_valid = 1'b0;
    chk("clear_valid_req_fall", ic_req, 0);
    fetch(32'h300, ADDI, 1'b0, 32'h304, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_no_req", ic_req, 0);
    end
    k = n_ins;
    fetch(32'h304, ADDI, 1'b0, 32'h308, 3);
    cyc(3);
    chk("emit_once", n_ins - k, 1);
    train(32'h10, 1'b1, 2);
    f_stall = 1'b0;
    cyc(1);
    f_stall = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_ic_req", ic_req, 0);
    chk("async_rst_is_ins", is_ins, 0);
    @(negedge clk_in);
    cyc(1);
    rst_in = 1'b0;
    fetch(32'h0, ADDI, 1'b0, 32'h4, 1);
    redirect(32'h10);
    fetch(32'h10, BEQM8, 1'b0, 32'h8, 1);
    fill(32'h14);
    cyc(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
